// File: rtl/alu_sequencer.sv
// Microcoded control sequencer for an accumulator/adder datapath.
// Optional macro SEQ_OVF_STOP_EN: carry during ADD/SUB ends the repeat early and flags ovf in DONE.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  input  logic       cf,
  output logic       nLa,
  output logic       nLb,
  output logic       Ea,
  output logic       Eu,
  output logic       sub,
  output logic       busy,
  output logic       done,
  output logic       halted,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, HALT} state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDA  = 3'b001;
  localparam logic [2:0] OP_LDB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_OUTA = 3'b101;
  localparam logic [2:0] OP_HLT  = 3'b111;

  state_t     state, state_nxt;
  logic [2:0] op;
  logic [4:0] cnt;
  logic       ovf_flag;
  logic       accept;
  logic       op_arith;
  logic       instr_arith;
  logic       ovf_hit;

  assign accept      = (state == IDLE) && instr_valid;
  assign op_arith    = (op == OP_ADD) || (op == OP_SUB);
  assign instr_arith = (instr[7:5] == OP_ADD) || (instr[7:5] == OP_SUB);

`ifdef SEQ_OVF_STOP_EN
  assign ovf_hit = (state == EXEC) && op_arith && cf;
`else
  logic unused_cf;
  assign unused_cf = cf;
  assign ovf_hit   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ovf_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        ovf_flag <= 1'b0;
      else if (ovf_hit)
        ovf_flag <= 1'b1;
    end
  end

  // Opcode and remaining count; non-arithmetic ops load zero so EXEC lasts one cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      op  <= instr[7:5];
      cnt <= instr_arith ? instr[4:0] : 5'd0;
    end else if ((state == EXEC) && (cnt != 5'd0)) begin
      cnt <= cnt - 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (instr_valid) state_nxt = (instr[7:5] == OP_HLT) ? HALT : EXEC;
      EXEC: if ((cnt == 5'd0) || ovf_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    nLa = 1'b1;
    nLb = 1'b1;
    Ea  = 1'b0;
    Eu  = 1'b0;
    sub = 1'b0;
    if (state == EXEC) begin
      case (op)
        OP_LDA:  nLa = 1'b0;
        OP_LDB:  nLb = 1'b0;
        OP_ADD:  begin Eu = 1'b1; nLa = 1'b0; end
        OP_SUB:  begin Eu = 1'b1; nLa = 1'b0; sub = 1'b1; end
        OP_OUTA: Ea = 1'b1;
        OP_NOP:  ;
        default: ;
      endcase
    end
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state == EXEC) || (state == DONE);
  assign done        = (state == DONE);
  assign halted      = (state == HALT);
  assign ovf         = (state == DONE) && ovf_flag;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer (honours SEQ_OVF_STOP_EN when defined).
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       cf = 1'b0;
  logic       instr_ready, nLa, nLb, Ea, Eu, sub, busy, done, halted, ovf;
  logic [4:0] ctrl;

  int checks = 0;
  int failures = 0;

`ifdef SEQ_OVF_STOP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam logic [4:0] IDLE_CTRL = 5'b11000;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .cf(cf), .nLa(nLa), .nLb(nLb), .Ea(Ea),
    .Eu(Eu), .sub(sub), .busy(busy), .done(done), .halted(halted), .ovf(ovf)
  );

  assign ctrl = {nLa, nLb, Ea, Eu, sub};

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] instr;
    int         cf_at;
    int         cycles;
    logic [4:0] ctrl;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Ea and Eu must never fight over the bus.
  always @(negedge clk) if (!rst) check("ea_eu_exclusive", {31'd0, Ea & Eu}, 32'd0);

  task automatic run_vec(input vec_t v);
    int n;
    for (int i = 0; i < 50 && !instr_ready; i++) @(negedge clk);
    check({v.name, "_ready_in"}, {31'd0, instr_ready}, 32'd1);
    instr = v.instr;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && !done && n < 40) begin
      n++;
      check({v.name, "_ctrl"}, {27'd0, ctrl}, {27'd0, v.ctrl});
      cf = (n == v.cf_at);
      @(negedge clk);
      cf = 1'b0;
    end
    check({v.name, "_cycles"}, n, v.cycles);
    check({v.name, "_done"}, {31'd0, done}, 32'd1);
    check({v.name, "_busy_done"}, {31'd0, busy}, 32'd1);
    check({v.name, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
    check({v.name, "_ctrl_done"}, {27'd0, ctrl}, {27'd0, IDLE_CTRL});
    @(negedge clk);
    check({v.name, "_ready_out"}, {31'd0, instr_ready}, 32'd1);
    check({v.name, "_busy_out"}, {31'd0, busy}, 32'd0);
    check({v.name, "_done_out"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"nop",      8'h00, 0, 1,  5'b11000, 1'b0};
    vecs[1]  = '{"lda",      8'h20, 0, 1,  5'b01000, 1'b0};
    vecs[2]  = '{"ldb",      8'h40, 0, 1,  5'b10000, 1'b0};
    vecs[3]  = '{"add_c4",   8'h64, 0, 5,  5'b01010, 1'b0};
    vecs[4]  = '{"sub_c0",   8'h80, 0, 1,  5'b01011, 1'b0};
    vecs[5]  = '{"outa",     8'hA0, 0, 1,  5'b11100, 1'b0};
    vecs[6]  = '{"nop_rsv",  8'hDF, 0, 1,  5'b11000, 1'b0};
    vecs[7]  = '{"lda_c31",  8'h3F, 1, 1,  5'b01000, 1'b0};
    vecs[8]  = '{"add_c31",  8'h7F, 0, 32, 5'b01010, 1'b0};
    vecs[9]  = '{"sub_cf2",  8'h85, 2, OVF_EN ? 2 : 6, 5'b01011, OVF_EN};
    vecs[10] = '{"add_cf3",  8'h7F, 3, OVF_EN ? 3 : 32, 5'b01010, OVF_EN};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_ctrl", {27'd0, ctrl}, {27'd0, IDLE_CTRL});
    check("rst_flags", {28'd0, busy, done, halted, ovf}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // SUB then OUTA with valid held continuously across DONE.
    @(negedge clk);
    instr = 8'h80;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = 8'hA0;
    @(negedge clk);
    check("b2b_sub_ctrl", {27'd0, ctrl}, 32'b01011);
    check("b2b_sub_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check("b2b_sub_done", {31'd0, done}, 32'd1);
    check("b2b_done_eu", {31'd0, Eu}, 32'd0);
    @(negedge clk);
    check("b2b_idle_ready", {31'd0, instr_ready}, 32'd1);
    check("b2b_idle_eu", {31'd0, Eu}, 32'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    check("b2b_outa_ctrl", {27'd0, ctrl}, 32'b11100);
    @(negedge clk);
    check("b2b_outa_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("b2b_final_ready", {31'd0, instr_ready}, 32'd1);

    // Reset two cycles into ADD c=3 aborts without a DONE pulse.
    instr = 8'h63;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("abort_exec1", {27'd0, ctrl}, 32'b01010);
    @(negedge clk);
    check("abort_exec2", {27'd0, ctrl}, 32'b01010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ctrl", {27'd0, ctrl}, {27'd0, IDLE_CTRL});
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    check("abort_no_late_done", {31'd0, done}, 32'd0);

    // HLT holds until reset even with a valid LDA offered.
    instr = 8'hE0;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = 8'h20;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_ready", {31'd0, instr_ready}, 32'd0);
      check("halt_busy", {31'd0, busy}, 32'd0);
      check("halt_ctrl", {27'd0, ctrl}, {27'd0, IDLE_CTRL});
    end
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    check("halt_rst_ready", {31'd0, instr_ready}, 32'd1);

    // Reset coinciding with acceptance drops the instruction.
    instr = 8'h20;
    instr_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
    check("rst_accept_busy", {31'd0, busy}, 32'd0);
    check("rst_accept_nla", {31'd0, nLa}, 32'd1);
    check("rst_accept_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    check("rst_accept_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
